uart_fifo_ip: RTL and testbench
===============================

// Module: uart_fifo_ip
// PURPOSE
//  Next-generation UART peripheral on the local bus: TX and RX FIFOs, programmable divisor,
//  optional parity and 2-stop mode, error flags and an interrupt line.
//  Sits beside the other bus slaves; the CPU pushes bytes to TXDATA and pops bytes from RXDATA.
// PARAMETERS
//  ADDR_W       32   bus address width
//  DATA_W       32   bus data width
//  STRB_W       DATA_W/8  write strobe width
//  FIFO_DEPTH   16   entries per FIFO, power of 2, >=2
//  DIV_W        16   divisor width
//  DEFAULT_DIV  28   reset divisor (clocks per bit - 1); 3.375 MHz / 115200
// PORTS
//  clk       in   1       system clock
//  rst       in   1       synchronous reset, active-high
//  waddr     in   ADDR_W  write address; register select = waddr[4:2]
//  wdata     in   DATA_W  write data
//  wen       in   1       write enable
//  wstrb     in   STRB_W  byte strobes
//  wready    out  1       write accepted; tied 1, single-cycle writes
//  raddr     in   ADDR_W  read address; register select = raddr[4:2]
//  ren       in   1       read enable
//  rdata     out  DATA_W  registered read data, valid with rvalid
//  rvalid    out  1       one-cycle pulse, 1 clk after ren
//  o_uart_tx out  1       serial out, idle high
//  i_uart_rx in   1       serial in, asynchronous
//  o_irq     out  1       registered interrupt
// BEHAVIOUR
//  Reset: CTRL=0, DIV=DEFAULT_DIV, FIFOs empty, flags 0, o_uart_tx=1, rdata=0, rvalid=0, o_irq=0.
//  Registers; byte fields written only when their wstrb bit is set; unmapped reads return 0:
//   0x00 CTRL  [0]en [1]par_en [2]par_odd [3]stop2 [4]rx_ie [5]tx_ie
//   0x04 DIV   [DIV_W-1:0] bit period = DIV+1 clocks; DIV<3 is clamped to 3
//   0x08 STAT  RO: [0]tx_full [1]tx_empty [2]rx_empty [3]rx_full [4]tx_busy
//              W1C: [5]rx_ovr [6]frame_err [7]par_err [8]tx_ovr
//   0x0C TXDATA  write [7:0] pushes TX FIFO; if full, byte dropped and tx_ovr set
//   0x10 RXDATA  read pops RX FIFO: {23'b0, valid, data[7:0]}; empty -> 0, no pop
//  FIFOs: circular, ptr width log2(DEPTH)+1; same-cycle push+pop legal, count unchanged.
//   Full RX FIFO with pop in the same cycle accepts the new byte.
//  TX FSM: IDLE->START->DATA(8, LSB first)->[PARITY]->STOP(1 or 2 bits)->IDLE.
//   Leaves IDLE when en=1 and TX FIFO non-empty; pops on the IDLE->START edge.
//   tx_busy=1 outside IDLE. Back-to-back frames have no idle gap.
//  RX: i_uart_rx passes a 2-flop synchroniser.
//   RX FSM: IDLE->START->DATA->[PARITY]->STOP->IDLE.
//   Falling edge in IDLE starts a half-bit count (DIV>>1). Line still 0 at mid-start -> DATA;
//   line 1 -> glitch, return to IDLE. Data and stop bits sampled at bit centres.
//   Parity mismatch sets par_err. Stop=0 sets frame_err. With stop2, only the first stop bit is checked.
//   The byte is pushed even on error. Push into a full FIFO (no pop) drops the byte and sets rx_ovr.
//  en=0: both FSMs forced to IDLE at the next clk. o_uart_tx=1. FIFO contents and flags kept.
//  rst mid-frame: FSMs to IDLE immediately, line high, FIFOs flushed.
//  Parity: even = XOR of data; odd = inverted.
//  o_irq <= (rx_ie & !rx_empty) | (tx_ie & tx_empty) | rx_ovr | frame_err | par_err.
//  Simultaneous W1C write and hardware set of a flag: set wins.
// CONFIGURATION
//  UART_LOOPBACK_EN defined:
//   CTRL[6] = loop. When loop=1, the RX FSM takes the internal TX bit and o_uart_tx is held 1.
//  UART_LOOPBACK_EN undefined:
//   CTRL[6] reads 0 and writes to it are ignored. RX always uses i_uart_rx.
// TESTING
//  T1: DIV=28, en=1, write TXDATA 0x55 -> o_uart_tx: start 0, then 1,0,1,0,1,0,1,0, stop 1.
//      Each bit lasts 29 clk; tx_busy falls 290 clk after the push.
//  T2: write 17 bytes with FIFO_DEPTH=16 and en=0 -> tx_full=1, tx_ovr=1.
//      Set en=1 -> exactly 16 frames transmitted, then tx_empty=1.
//  T3: drive RX frame 0xA3 with par_en=1, par_odd=0 and a correct parity bit -> rx_empty=0.
//      RXDATA read returns 0x1A3; rvalid pulses 1 clk after ren.
//  T4: same frame with parity bit flipped -> par_err=1 and o_irq=1.
//      Write STAT 0x80 -> par_err=0.
//  T5: send 17 RX bytes without reading -> rx_full=1, rx_ovr=1; bytes 1..16 are read back in order.
//  T6: assert rst during TX DATA bit 3 -> next clk o_uart_tx=1, FIFOs empty, CTRL=0.
//      With UART_LOOPBACK_EN and loop=1, TX 0x3C is received as 0x13C.

Source files
------------

// File: rtl/uart_fifo_ip.sv
// UART peripheral: TX/RX FIFOs, programmable divisor, optional parity, 2-stop mode, error flags, irq.
// Build option UART_LOOPBACK_EN adds CTRL[6] loop, which routes the internal TX bit into the RX FSM.
//
// state    | meaning (shared by TX and RX FSMs)
// S_IDLE   | line idle; TX waits for en and data, RX waits for a falling edge
// S_START  | start bit; RX checks the line at mid-start to reject glitches
// S_DATA   | 8 data bits, LSB first
// S_PARITY | optional parity bit
// S_STOP   | stop bit(s); TX may chain straight into the next START
module uart_fifo_ip #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int STRB_W      = DATA_W / 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 28
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wen,
  input  logic [STRB_W-1:0] wstrb,
  output logic              wready,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              ren,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              o_uart_tx,
  input  logic              i_uart_rx,
  output logic              o_irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} uart_state_t;

  logic [5:0]        ctrl_q;
  logic              en, par_en, par_odd, stop2, rx_ie, tx_ie, loop;
  logic [DIV_W-1:0]  div_q, div_n, div_eff;
  logic [DATA_W-1:0] div_wide, rd_mux;
  logic              rx_ovr, frame_err, par_err, tx_ovr;
  logic              w_ctrl, w_div, w_stat, w_txd, r_rxd;

  logic [7:0]        tx_mem [FIFO_DEPTH];
  logic [PW-1:0]     tx_wp, tx_rp;
  logic              tx_empty, tx_full, tx_push, tx_pop, tx_ovr_set;
  logic [7:0]        tx_head;

  logic [7:0]        rx_mem [FIFO_DEPTH];
  logic [PW-1:0]     rx_wp, rx_rp;
  logic              rx_empty, rx_full, rx_wr, rx_pop, rx_ovr_set;

  uart_state_t       tx_state, tx_state_n, rx_state, rx_state_n;
  logic [DIV_W-1:0]  tx_cnt, tx_cnt_n, rx_cnt, rx_cnt_n;
  logic [2:0]        tx_bitn, tx_bitn_n, rx_bitn, rx_bitn_n;
  logic [7:0]        tx_shift, tx_shift_n, rx_shift, rx_shift_n;
  logic              tx_par, tx_par_n, tx_second, tx_second_n, tx_load_ok, tx_bit, tx_busy;
  logic              rx_s1, rx_s2, rx_prev, rx_in, rx_pbad, rx_pbad_n;
  logic              rx_push, rx_frame_set, rx_par_set;
  logic              unused_bits;

  assign {tx_ie, rx_ie, stop2, par_odd, par_en, en} = ctrl_q;
  assign wready  = 1'b1;
  assign w_ctrl  = wen && (waddr[4:2] == 3'd0);
  assign w_div   = wen && (waddr[4:2] == 3'd1);
  assign w_stat  = wen && (waddr[4:2] == 3'd2);
  assign w_txd   = wen && (waddr[4:2] == 3'd3) && wstrb[0];
  assign r_rxd   = ren && (raddr[4:2] == 3'd4);
  assign div_eff = (div_q < DIV_W'(3)) ? DIV_W'(3) : div_q;
  assign unused_bits = ^{waddr, raddr, wdata, wstrb, div_wide};

`ifdef UART_LOOPBACK_EN
  logic loop_q;
  always_ff @(posedge clk) begin
    if (rst)                      loop_q <= 1'b0;
    else if (w_ctrl && wstrb[0])  loop_q <= wdata[6];
  end
  assign loop = loop_q;
`else
  assign loop = 1'b0;
`endif

  assign tx_empty   = (tx_wp == tx_rp);
  assign tx_full    = (tx_wp[PW-1] != tx_rp[PW-1]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
  assign tx_push    = w_txd && !tx_full;
  assign tx_ovr_set = w_txd && tx_full;
  assign tx_head    = tx_mem[tx_rp[AW-1:0]];

  assign rx_empty   = (rx_wp == rx_rp);
  assign rx_full    = (rx_wp[PW-1] != rx_rp[PW-1]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
  assign rx_pop     = r_rxd && !rx_empty;
  assign rx_wr      = rx_push && (!rx_full || rx_pop);
  assign rx_ovr_set = rx_push && rx_full && !rx_pop;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[AW-1:0]] <= wdata[7:0];
    if (rx_wr)   rx_mem[rx_wp[AW-1:0]] <= rx_shift;
  end

  always_comb begin
    div_wide = '0;
    div_wide[DIV_W-1:0] = div_q;
    for (int i = 0; i < STRB_W; i++)
      if (wstrb[i]) div_wide[i*8 +: 8] = wdata[i*8 +: 8];
    div_n = div_wide[DIV_W-1:0];
  end

  always_comb begin
    tx_state_n  = tx_state;
    tx_cnt_n    = tx_cnt - DIV_W'(1);
    tx_bitn_n   = tx_bitn;
    tx_shift_n  = tx_shift;
    tx_par_n    = tx_par;
    tx_second_n = tx_second;
    tx_pop      = 1'b0;
    tx_load_ok  = 1'b0;
    case (tx_state)
      S_IDLE: tx_load_ok = 1'b1;
      S_START:
        if (tx_cnt == '0) begin
          tx_state_n = S_DATA;
          tx_cnt_n   = div_eff;
          tx_bitn_n  = 3'd0;
        end
      S_DATA:
        if (tx_cnt == '0) begin
          tx_cnt_n    = div_eff;
          tx_shift_n  = tx_shift >> 1;
          tx_bitn_n   = tx_bitn + 3'd1;
          tx_second_n = 1'b0;
          if (tx_bitn == 3'd7) tx_state_n = par_en ? S_PARITY : S_STOP;
        end
      S_PARITY:
        if (tx_cnt == '0) begin
          tx_state_n = S_STOP;
          tx_cnt_n   = div_eff;
        end
      S_STOP:
        if (tx_cnt == '0) begin
          tx_cnt_n = div_eff;
          if (stop2 && !tx_second) begin
            tx_second_n = 1'b1;
          end else begin
            tx_state_n = S_IDLE;
            tx_load_ok = 1'b1;
          end
        end
      default: tx_state_n = S_IDLE;
    endcase
    // Loading straight out of the last stop bit keeps back-to-back frames gapless.
    if (tx_load_ok && en && !tx_empty) begin
      tx_state_n = S_START;
      tx_cnt_n   = div_eff;
      tx_pop     = 1'b1;
      tx_shift_n = tx_head;
      tx_par_n   = (^tx_head) ^ par_odd;
    end
    if (!en) begin
      tx_state_n = S_IDLE;
      tx_pop     = 1'b0;
    end
  end

  always_comb begin
    case (tx_state)
      S_START:  tx_bit = 1'b0;
      S_DATA:   tx_bit = tx_shift[0];
      S_PARITY: tx_bit = tx_par;
      default:  tx_bit = 1'b1;
    endcase
  end
  assign tx_busy   = (tx_state != S_IDLE);
  assign o_uart_tx = loop ? 1'b1 : tx_bit;
  assign rx_in     = loop ? tx_bit : rx_s2;

  always_comb begin
    rx_state_n   = rx_state;
    rx_cnt_n     = rx_cnt - DIV_W'(1);
    rx_bitn_n    = rx_bitn;
    rx_shift_n   = rx_shift;
    rx_pbad_n    = rx_pbad;
    rx_push      = 1'b0;
    rx_frame_set = 1'b0;
    rx_par_set   = 1'b0;
    case (rx_state)
      S_IDLE: begin
        rx_cnt_n = rx_cnt;
        if (rx_prev && !rx_in) begin
          rx_state_n = S_START;
          rx_cnt_n   = div_eff >> 1;
          rx_pbad_n  = 1'b0;
        end
      end
      S_START:
        if (rx_cnt == '0) begin
          rx_state_n = rx_in ? S_IDLE : S_DATA;
          rx_cnt_n   = div_eff;
          rx_bitn_n  = 3'd0;
        end
      S_DATA:
        if (rx_cnt == '0) begin
          rx_shift_n = {rx_in, rx_shift[7:1]};
          rx_bitn_n  = rx_bitn + 3'd1;
          rx_cnt_n   = div_eff;
          if (rx_bitn == 3'd7) rx_state_n = par_en ? S_PARITY : S_STOP;
        end
      S_PARITY:
        if (rx_cnt == '0) begin
          rx_pbad_n  = rx_in ^ (^rx_shift) ^ par_odd;
          rx_state_n = S_STOP;
          rx_cnt_n   = div_eff;
        end
      S_STOP:
        if (rx_cnt == '0) begin
          rx_push      = 1'b1;
          rx_frame_set = !rx_in;
          rx_par_set   = rx_pbad;
          rx_state_n   = S_IDLE;
        end
      default: rx_state_n = S_IDLE;
    endcase
    if (!en) begin
      rx_state_n   = S_IDLE;
      rx_push      = 1'b0;
      rx_frame_set = 1'b0;
      rx_par_set   = 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (raddr[4:2])
      3'd0: rd_mux[6:0] = {loop, ctrl_q};
      3'd1: rd_mux[DIV_W-1:0] = div_q;
      3'd2: rd_mux[8:0] = {tx_ovr, par_err, frame_err, rx_ovr, tx_busy,
                           rx_full, rx_empty, tx_empty, tx_full};
      3'd4: if (!rx_empty) rd_mux[8:0] = {1'b1, rx_mem[rx_rp[AW-1:0]]};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q    <= '0;
      div_q     <= DIV_W'(DEFAULT_DIV);
      {rx_ovr, frame_err, par_err, tx_ovr} <= '0;
      tx_wp     <= '0;
      tx_rp     <= '0;
      rx_wp     <= '0;
      rx_rp     <= '0;
      tx_state  <= S_IDLE;
      tx_cnt    <= '0;
      tx_bitn   <= '0;
      tx_shift  <= '0;
      tx_par    <= 1'b0;
      tx_second <= 1'b0;
      rx_state  <= S_IDLE;
      rx_cnt    <= '0;
      rx_bitn   <= '0;
      rx_shift  <= '0;
      rx_pbad   <= 1'b0;
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_prev   <= 1'b1;
      rdata     <= '0;
      rvalid    <= 1'b0;
      o_irq     <= 1'b0;
    end else begin
      if (w_ctrl && wstrb[0]) ctrl_q <= wdata[5:0];
      if (w_div) div_q <= div_n;
      // A hardware set in the same cycle as a W1C clear wins.
      rx_ovr    <= (rx_ovr    & ~(w_stat & wstrb[0] & wdata[5])) | rx_ovr_set;
      frame_err <= (frame_err & ~(w_stat & wstrb[0] & wdata[6])) | rx_frame_set;
      par_err   <= (par_err   & ~(w_stat & wstrb[0] & wdata[7])) | rx_par_set;
      tx_ovr    <= (tx_ovr    & ~(w_stat & wstrb[1] & wdata[8])) | tx_ovr_set;
      if (tx_push) tx_wp <= tx_wp + PW'(1);
      if (tx_pop)  tx_rp <= tx_rp + PW'(1);
      if (rx_wr)   rx_wp <= rx_wp + PW'(1);
      if (rx_pop)  rx_rp <= rx_rp + PW'(1);
      tx_state  <= tx_state_n;
      tx_cnt    <= tx_cnt_n;
      tx_bitn   <= tx_bitn_n;
      tx_shift  <= tx_shift_n;
      tx_par    <= tx_par_n;
      tx_second <= tx_second_n;
      rx_state  <= rx_state_n;
      rx_cnt    <= rx_cnt_n;
      rx_bitn   <= rx_bitn_n;
      rx_shift  <= rx_shift_n;
      rx_pbad   <= rx_pbad_n;
      rx_s1     <= i_uart_rx;
      rx_s2     <= rx_s1;
      rx_prev   <= rx_in;
      rvalid    <= ren;
      if (ren) rdata <= rd_mux;
      o_irq     <= (rx_ie & ~rx_empty) | (tx_ie & tx_empty) | rx_ovr | frame_err | par_err;
    end
  end
endmodule

// File: tb/tb_uart_fifo_ip.sv
// Directed self-checking bench for uart_fifo_ip: registers, TX framing, FIFOs, RX errors, reset.
// Define UART_LOOPBACK_EN to exercise the internal loopback path.
module tb_uart_fifo_ip;
  localparam logic [31:0] A_CTRL = 32'h00, A_DIV = 32'h04, A_STAT = 32'h08,
                          A_TXD = 32'h0C, A_RXD = 32'h10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] waddr = '0, wdata = '0, raddr = '0;
  logic        wen = 1'b0, ren = 1'b0;
  logic [3:0]  wstrb = '0;
  logic        wready, rvalid, o_uart_tx, o_irq;
  logic [31:0] rdata;
  logic        i_uart_rx = 1'b1;
  int          total = 0;
  int          bad = 0;

  uart_fifo_ip dut (
    .clk(clk), .rst(rst), .waddr(waddr), .wdata(wdata), .wen(wen), .wstrb(wstrb),
    .wready(wready), .raddr(raddr), .ren(ren), .rdata(rdata), .rvalid(rvalid),
    .o_uart_tx(o_uart_tx), .i_uart_rx(i_uart_rx), .o_irq(o_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk); waddr = a; wdata = d; wstrb = s; wen = 1'b1;
    @(negedge clk); wen = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic v);
    @(negedge clk); raddr = a; ren = 1'b1;
    @(negedge clk); ren = 1'b0; d = rdata; v = rvalid;
  endtask

  task automatic drive_bit(input logic b, input int clks);
    i_uart_rx = b;
    repeat (clks) @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b, input bit par, input logic pbit,
                         input logic stop_bit, input int bclk);
    drive_bit(1'b0, bclk);
    for (int i = 0; i < 8; i++) drive_bit(b[i], bclk);
    if (par) drive_bit(pbit, bclk);
    drive_bit(stop_bit, bclk);
    drive_bit(1'b1, 2 * bclk);
  endtask

  // Software receiver on o_uart_tx; returns at the centre of the stop bit.
  task automatic sniff_tx(input int bclk, input int limit, output logic [7:0] b,
                          output bit found, output int waited);
    found = 1'b0; b = '0; waited = 0;
    while (o_uart_tx !== 1'b0 && waited < limit) begin
      @(negedge clk); waited++;
    end
    if (o_uart_tx === 1'b0) begin
      found = 1'b1;
      repeat (bclk + bclk / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        b[i] = o_uart_tx;
        if (i < 7) repeat (bclk) @(negedge clk);
      end
      repeat (bclk) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    logic [31:0] d; logic v;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (o_uart_tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", o_uart_tx); end
    total++; if (o_irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", o_irq); end
    total++; if (rvalid !== 1'b0 || rdata !== 32'h0) begin bad++; $display("FAIL reset_rd: got rvalid=%b rdata=%h want 0/0", rvalid, rdata); end
    total++; if (wready !== 1'b1) begin bad++; $display("FAIL wready: got %b want 1", wready); end
    bus_read(A_CTRL, d, v);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_ctrl: got %h want 0", d); end
    bus_read(A_DIV, d, v);
    total++; if (d !== 32'd28) begin bad++; $display("FAIL reset_div: got %h want 1c", d); end
    bus_read(A_STAT, d, v);
    total++; if (d !== 32'h006) begin bad++; $display("FAIL reset_stat: got %h want 006", d); end
  endtask

  task automatic test_regs;
    logic [31:0] d; logic v;
    bus_write(A_DIV, 32'h0000_1234, 4'h1);
    bus_read(A_DIV, d, v);
    total++; if (d !== 32'h0034) begin bad++; $display("FAIL div_strb_lo: got %h want 0034", d); end
    bus_write(A_DIV, 32'h0000_5600, 4'h2);
    bus_read(A_DIV, d, v);
    total++; if (d !== 32'h5634) begin bad++; $display("FAIL div_strb_hi: got %h want 5634", d); end
    bus_write(A_CTRL, 32'h0000_003F, 4'h0);
    bus_read(A_CTRL, d, v);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL ctrl_nostrb: got %h want 0", d); end
    bus_write(A_DIV, 32'd28, 4'hF);
    bus_read(32'h14, d, v);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL unmapped: got %h want 0", d); end
  endtask

  task automatic test_tx_frame;
    logic [9:0] frame;
    int w;
    frame = {1'b1, 8'h55, 1'b0};
    bus_write(A_CTRL, 32'h1, 4'h1);
    bus_write(A_TXD, 32'h55, 4'h1);
    raddr = A_STAT; ren = 1'b1;
    w = 0;
    do begin @(negedge clk); w++; end while (o_uart_tx !== 1'b0 && w < 100);
    total++; if (o_uart_tx !== 1'b0) begin bad++; $display("FAIL t1_start: got %b want 0 within 100 clk", o_uart_tx); end
    for (int t = 0; t <= 291; t++) begin
      if (t > 0) @(negedge clk);
      if ((t % 29) == 14 && (t / 29) < 10) begin
        total++;
        if (o_uart_tx !== frame[t / 29]) begin
          bad++; $display("FAIL t1_bit%0d: got %b want %b", t / 29, o_uart_tx, frame[t / 29]);
        end
      end
      if (t == 290) begin
        total++; if (rdata[4] !== 1'b1) begin bad++; $display("FAIL t1_busy_290: got %b want 1", rdata[4]); end
      end
      if (t == 291) begin
        total++; if (rdata[4] !== 1'b0) begin bad++; $display("FAIL t1_busy_291: got %b want 0", rdata[4]); end
      end
    end
    ren = 1'b0;
  endtask

  task automatic test_tx_fifo;
    logic [31:0] d; logic v; logic [7:0] b; bit found; int waited; int frames;
    bus_write(A_CTRL, 32'h0, 4'h1);
    bus_write(A_DIV, 32'h0, 4'hF);
    for (int i = 0; i < 17; i++) bus_write(A_TXD, 32'h10 + i, 4'h1);
    bus_read(A_STAT, d, v);
    total++; if (d !== 32'h105) begin bad++; $display("FAIL t2_stat_full: got %h want 105", d); end
    bus_read(A_DIV, d, v);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL t2_div0: got %h want 0", d); end
    bus_write(A_CTRL, 32'h1, 4'h1);
    frames = 0;
    for (int f = 0; f < 17; f++) begin
      sniff_tx(4, 100, b, found, waited);
      if (found) begin
        frames++;
        total++; if (b !== 8'(8'h10 + f)) begin bad++; $display("FAIL t2_byte%0d: got %h want %h", f, b, 8'(8'h10 + f)); end
        if (f > 0) begin
          total++; if (waited != 2) begin bad++; $display("FAIL t2_gap%0d: got %0d want 2", f, waited); end
        end
      end
    end
    total++; if (frames != 16) begin bad++; $display("FAIL t2_frames: got %0d want 16", frames); end
    bus_read(A_STAT, d, v);
    total++; if (d !== 32'h106) begin bad++; $display("FAIL t2_stat_empty: got %h want 106", d); end
    bus_write(A_STAT, 32'h100, 4'hF);
    bus_read(A_STAT, d, v);
    total++; if (d !== 32'h006) begin bad++; $display("FAIL t2_w1c: got %h want 006", d); end
  endtask

  task automatic test_rx_parity;
    logic [31:0] d; logic v;
    bus_write(A_DIV, 32'd15, 4'hF);
    bus_write(A_CTRL, 32'h3, 4'h1);
    send_rx(8'hA3, 1'b1, 1'b0, 1'b1, 16);
    bus_read(A_STAT, d, v);
    total++; if (d !== 32'h002) begin bad++; $display("FAIL t3_stat: got %h want 002", d); end
    bus_read(A_RXD, d, v);
    total++; if (d !== 32'h1A3) begin bad++; $display("FAIL t3_rxdata: got %h want 1a3", d); end
    total++; if (v !== 1'b1) begin bad++; $display("FAIL t3_rvalid: got %b want 1", v); end
    @(negedge clk);
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL t3_rvalid_pulse: got %b want 0", rvalid); end
    bus_read(A_RXD, d, v);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL t3_empty_read: got %h want 0", d); end
    bus_write(A_CTRL, 32'h7, 4'h1);
    send_rx(8'h5B, 1'b1, 1'b0, 1'b1, 16);
    bus_read(A_STAT, d, v);
    total++; if (d !== 32'h002) begin bad++; $display("FAIL t3_odd_stat: got %h want 002", d); end
    bus_read(A_RXD, d, v);
    total++; if (d !== 32'h15B) begin bad++; $display("FAIL t3_odd_data: got %h want 15b", d); end
  endtask

  task automatic test_rx_errors;
    logic [31:0] d; logic v;
    bus_write(A_CTRL, 32'h3, 4'h1);
    send_rx(8'hA3, 1'b1, 1'b1, 1'b1, 16);
    bus_read(A_STAT, d, v);
    total++; if (d !== 32'h082) begin bad++; $display("FAIL t4_par_err: got %h want 082", d); end
    total++; if (o_irq !== 1'b1) begin bad++; $display("FAIL t4_irq: got %b want 1", o_irq); end
    bus_write(A_STAT, 32'h80, 4'h1);
    bus_read(A_STAT, d, v);
    total++; if (d !== 32'h002) begin bad++; $display("FAIL t4_clear: got %h want 002", d); end
    bus_read(A_RXD, d, v);
    total++; if (d !== 32'h1A3) begin bad++; $display("FAIL t4_data: got %h want 1a3", d); end
    repeat (2) @(negedge clk);
    total++; if (o_irq !== 1'b0) begin bad++; $display("FAIL t4_irq_low: got %b want 0", o_irq); end
    bus_write(A_CTRL, 32'h1, 4'h1);
    send_rx(8'h5A, 1'b0, 1'b0, 1'b0, 16);
    bus_read(A_STAT, d, v);
    total++; if (d !== 32'h042) begin bad++; $display("FAIL frame_err: got %h want 042", d); end
    bus_write(A_STAT, 32'h40, 4'h1);
    bus_read(A_RXD, d, v);
    total++; if (d !== 32'h15A) begin bad++; $display("FAIL frame_data: got %h want 15a", d); end
    drive_bit(1'b0, 3);
    drive_bit(1'b1, 48);
    bus_read(A_STAT, d, v);
    total++; if (d !== 32'h006) begin bad++; $display("FAIL glitch: got %h want 006", d); end
  endtask

  task automatic test_rx_overflow;
    logic [31:0] d; logic v;
    bus_write(A_CTRL, 32'h1, 4'h1);
    for (int i = 0; i < 17; i++) send_rx(8'((i * 19 + 33) & 255), 1'b0, 1'b0, 1'b1, 16);
    bus_read(A_STAT, d, v);
    total++; if (d !== 32'h02A) begin bad++; $display("FAIL t5_stat: got %h want 02a", d); end
    total++; if (o_irq !== 1'b1) begin bad++; $display("FAIL t5_irq: got %b want 1", o_irq); end
    for (int i = 0; i < 16; i++) begin
      bus_read(A_RXD, d, v);
      total++;
      if (d !== {23'b0, 1'b1, 8'((i * 19 + 33) & 255)}) begin
        bad++; $display("FAIL t5_byte%0d: got %h want %h", i, d, {23'b0, 1'b1, 8'((i * 19 + 33) & 255)});
      end
    end
    bus_read(A_RXD, d, v);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL t5_drained: got %h want 0", d); end
    bus_write(A_STAT, 32'h20, 4'h1);
    bus_read(A_STAT, d, v);
    total++; if (d !== 32'h006) begin bad++; $display("FAIL t5_clear: got %h want 006", d); end
    bus_write(A_CTRL, 32'h21, 4'h1);
    repeat (2) @(negedge clk);
    total++; if (o_irq !== 1'b1) begin bad++; $display("FAIL tx_ie_irq: got %b want 1", o_irq); end
    bus_write(A_CTRL, 32'h11, 4'h1);
    repeat (2) @(negedge clk);
    total++; if (o_irq !== 1'b0) begin bad++; $display("FAIL rx_ie_irq: got %b want 0", o_irq); end
  endtask

  task automatic test_reset_midframe;
    logic [31:0] d; logic v; int w; int lows;
    bus_write(A_CTRL, 32'h0, 4'h1);
    bus_write(A_DIV, 32'd3, 4'hF);
    bus_write(A_TXD, 32'hF7, 4'h1);
    bus_write(A_TXD, 32'h11, 4'h1);
    bus_write(A_CTRL, 32'h1, 4'h1);
    w = 0;
    while (o_uart_tx !== 1'b0 && w < 50) begin @(negedge clk); w++; end
    repeat (17) @(negedge clk);
    total++; if (o_uart_tx !== 1'b0) begin bad++; $display("FAIL t6_bit3: got %b want 0", o_uart_tx); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (o_uart_tx !== 1'b1) begin bad++; $display("FAIL t6_tx_high: got %b want 1", o_uart_tx); end
    rst = 1'b0;
    bus_read(A_STAT, d, v);
    total++; if (d !== 32'h006) begin bad++; $display("FAIL t6_stat: got %h want 006", d); end
    bus_read(A_CTRL, d, v);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL t6_ctrl: got %h want 0", d); end
    lows = 0;
    for (int i = 0; i < 60; i++) begin @(negedge clk); if (o_uart_tx !== 1'b1) lows++; end
    total++; if (lows != 0) begin bad++; $display("FAIL t6_quiet: got %0d low clks want 0", lows); end
  endtask

  task automatic test_loopback;
    logic [31:0] d; logic v; int lows;
    bus_write(A_DIV, 32'd3, 4'hF);
    bus_write(A_CTRL, 32'h41, 4'h1);
`ifdef UART_LOOPBACK_EN
    bus_write(A_TXD, 32'h3C, 4'h1);
    lows = 0;
    for (int i = 0; i < 100; i++) begin @(negedge clk); if (o_uart_tx !== 1'b1) lows++; end
    total++; if (lows != 0) begin bad++; $display("FAIL loop_tx_held: got %0d low clks want 0", lows); end
    bus_read(A_RXD, d, v);
    total++; if (d !== 32'h13C) begin bad++; $display("FAIL loop_rx: got %h want 13c", d); end
`else
    lows = 0;
    bus_read(A_CTRL, d, v);
    total++; if (d !== 32'h01) begin bad++; $display("FAIL loop_ignored: got %h want 01 (%0d)", d, lows); end
`endif
    bus_write(A_CTRL, 32'h0, 4'h1);
  endtask

  initial begin
    test_reset();
    test_regs();
    test_tx_frame();
    test_tx_fifo();
    test_rx_parity();
    test_rx_errors();
    test_rx_overflow();
    test_reset_midframe();
    test_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
